// File: rtl/maxpool2_stream_ctrl_pkg.sv
// Shared types and helpers for the streaming 2x2/stride-2 max-pool controller.
// State encodings are fixed so the frame sequencer can be probed by value.
package maxpool2_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_EVEN = 2'd1,
        ROW_ODD  = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2_lane_max.sv
// Combinational per-lane signed maximum of two packed pixel words.
// Lanes are independent; on a tie either operand is equal, so b is chosen.
module maxpool2_lane_max #(
    parameter int DATA_WIDTH = 16,
    parameter int Depth      = 1
) (
    input  logic [Depth*DATA_WIDTH-1:0] i_a,
    input  logic [Depth*DATA_WIDTH-1:0] i_b,
    output logic [Depth*DATA_WIDTH-1:0] o_max
);

    always_comb begin
        o_max = '0;
        for (int l = 0; l < Depth; l++) begin
            if ($signed(i_a[l*DATA_WIDTH +: DATA_WIDTH]) > $signed(i_b[l*DATA_WIDTH +: DATA_WIDTH]))
                o_max[l*DATA_WIDTH +: DATA_WIDTH] = i_a[l*DATA_WIDTH +: DATA_WIDTH];
            else
                o_max[l*DATA_WIDTH +: DATA_WIDTH] = i_b[l*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/maxpool2_stream_ctrl.sv
// Streaming 2x2/stride-2 max-pool sequencer: raster pixels in, one pooled pixel per window out.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows finish each window.
module maxpool2_stream_ctrl
    import maxpool2_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 28,
    parameter int InputW     = 28,
    parameter int Depth      = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [Depth*DATA_WIDTH-1:0] i_in_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [Depth*DATA_WIDTH-1:0] o_out_data,
    output logic                        o_busy,
    output logic                        o_frame_done
);

    localparam int PW    = Depth * DATA_WIDTH;
    localparam int CW    = cntWidth(InputW);
    localparam int RW    = cntWidth(InputH);
    localparam int HalfW = InputW / 2;
    localparam int LW    = cntWidth(HalfW);

    if ((InputH % 2) != 0) begin : g_oddH
        $error("maxpool2_stream_ctrl: InputH must be even");
    end
    if ((InputW % 2) != 0) begin : g_oddW
        $error("maxpool2_stream_ctrl: InputW must be even");
    end

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [PW-1:0]   r_pair;
    logic [PW-1:0]   r_outData;
    logic            r_outValid;
    logic [PW-1:0]   r_lineBuf [HalfW];

    logic            w_inReady;
    logic            w_inFire;
    logic            w_outFire;
    logic            w_lastCol;
    logic            w_lastRow;
    logic [LW-1:0]   w_lbIdx;
    logic [PW-1:0]   w_lbRd;
    logic [PW-1:0]   w_pairMax;
    logic [PW-1:0]   w_winMax;

    // Input stalls while a finished window is still waiting on the consumer
    assign w_inReady = ((r_state == ROW_EVEN) || (r_state == ROW_ODD)) && (!r_outValid || i_out_ready);
    assign w_inFire  = i_in_valid && w_inReady;
    assign w_outFire = r_outValid && i_out_ready;
    assign w_lastCol = (r_col == CW'(InputW - 1));
    assign w_lastRow = (r_row == RW'(InputH - 1));
    assign w_lbIdx   = LW'(r_col >> 1);
    assign w_lbRd    = r_lineBuf[w_lbIdx];

    maxpool2_lane_max #(.DATA_WIDTH(DATA_WIDTH), .Depth(Depth)) u_pairMax (
        .i_a   (r_pair),
        .i_b   (i_in_data),
        .o_max (w_pairMax)
    );

    maxpool2_lane_max #(.DATA_WIDTH(DATA_WIDTH), .Depth(Depth)) u_winMax (
        .i_a   (w_pairMax),
        .i_b   (w_lbRd),
        .o_max (w_winMax)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (i_start) w_nextState = ROW_EVEN;
            ROW_EVEN: if (w_inFire && w_lastCol) w_nextState = ROW_ODD;
            ROW_ODD:  if (w_inFire && w_lastCol) w_nextState = w_lastRow ? DRAIN : ROW_EVEN;
            DRAIN:    if (w_outFire) w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_inFire) begin
            if (w_lastCol) begin
                r_col <= '0;
                r_row <= w_lastRow ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_pair <= '0;
        else if (w_inFire && !r_col[0]) r_pair <= i_in_data;
    end

    // Line buffer holds no reset; every entry is rewritten on each even row before it is read
    always_ff @(posedge i_clk) begin
        if (w_inFire && r_col[0] && (r_state == ROW_EVEN))
            r_lineBuf[w_lbIdx] <= w_pairMax;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else if (w_inFire && r_col[0] && (r_state == ROW_ODD)) begin
            r_outData  <= w_winMax;
            r_outValid <= 1'b1;
        end else if (w_outFire) begin
            r_outValid <= 1'b0;
        end
    end

    assign o_in_ready   = w_inReady;
    assign o_out_valid  = r_outValid;
    assign o_out_data   = r_outData;
    assign o_busy       = (r_state != IDLE);
    assign o_frame_done = (r_state == DRAIN) && w_outFire;

endmodule
